data_mem_axi_master: RTL and testbench
======================================

DATA_MEM_AXI_MASTER -- requirements
Module: data_mem_axi_master

Interface
REQ-001 Parameters (name, default, meaning): AXI_ADDR_WIDTH, 32, AXI address width.
REQ-002 AXI_DATA_WIDTH, 32, AXI data width; SHALL be 32 or 64.
REQ-003 AXI_ID_MASTER_WIDTH, 4, AXI ID width.
REQ-004 AXI_USER_WIDTH, 1, AXI user width.
REQ-005 AXI_ID, 0, constant ID driven on AW and AR.
REQ-006 Ports (name, direction, width, meaning): clk, input, 1, sole clock; all logic rising-edge.
REQ-007 rst, input, 1, synchronous active-high reset.
REQ-008 req_i, input, 1, core requests one access.
REQ-009 gnt_o, output, 1, request accepted this cycle.
REQ-010 addr_i, input, AXI_ADDR_WIDTH, byte address.
REQ-011 we_i, input, 1, 1 = write, 0 = read.
REQ-012 be_i, input, AXI_DATA_WIDTH/8, write byte enables.
REQ-013 wdata_i, input, AXI_DATA_WIDTH, write data.
REQ-014 rvalid_o, output, 1, one-cycle completion pulse for reads and writes.
REQ-015 rdata_o, output, AXI_DATA_WIDTH, read data, valid with rvalid_o.
REQ-016 err_o, output, 1, response was SLVERR or DECERR, valid with rvalid_o.
REQ-017 master, AXI_BUS.Master, -, AXI4 master port.

Function
REQ-018 The block SHALL have at most one transaction outstanding.
REQ-019 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-020 In IDLE, gnt_o SHALL equal req_i; in every other state gnt_o SHALL be 0.
REQ-021 On a grant, the block SHALL register addr_i, we_i, be_i and wdata_i, then go to WR_REQ if we_i = 1, else to RD_REQ.
REQ-022 WR_REQ SHALL assert aw_valid and w_valid from the next cycle, track each handshake independently, drop each valid after its own handshake, and go to WR_RESP once both handshakes are done (same or different cycles).
REQ-023 RD_REQ SHALL assert ar_valid until ar_ready, then go to RD_RESP.
REQ-024 b_ready SHALL be 1 only in WR_RESP, and r_ready only in RD_RESP.
REQ-025 A b or r handshake SHALL return the FSM to IDLE.
REQ-026 In the cycle after that handshake, the block SHALL drive rvalid_o = 1 and err_o = resp[1]; for reads, rdata_o = r_data.
REQ-027 rdata_o SHALL hold its value until the next read completes.
REQ-028 While valid is high, AXI payloads SHALL stay stable and valid SHALL NOT drop before its handshake.
REQ-029 AXI fields SHALL be: len = 0, size = log2(AXI_DATA_WIDTH/8), burst = INCR, w_last = 1, id = AXI_ID, w_strb = registered be, and lock, cache, prot, qos, region and user all 0.
REQ-030 Address SHALL pass unmodified; the slave handles misalignment.
REQ-031 Timing with a zero-wait slave: grant in cycle 0, AW/W or AR valid in cycle 1, response in cycle 2, rvalid_o in cycle 3.
REQ-032 A new grant SHALL be allowed in the same cycle as rvalid_o, giving back-to-back accesses every 3 cycles.
REQ-033 A b or r response arriving while its ready is low SHALL NOT be consumed.
REQ-034 Read data and a read error in the same response SHALL report rvalid_o = 1, err_o = 1 and the captured rdata_o.

Reset
REQ-035 When rst is 1 at a clock edge, the FSM SHALL enter IDLE, and all AXI valid/ready outputs, gnt_o, rvalid_o, err_o and rdata_o SHALL be 0 from the next cycle.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no completion pulse; the system resets the slave in the same cycle.

Structure
REQ-037 The state enum and the AXI resp/burst constants (OKAY, EXOKAY, SLVERR, DECERR, INCR) SHALL live in the shared package data_mem_axi_pkg.
REQ-038 The block SHALL be a single module with no sub-module; it connects to the existing AXI slave memory through AXI_BUS.

Verification
REQ-039 Write: 0x100 / 0xDEADBEEF / be 0xF to a zero-wait slave -> AW/W in cycle 1, b_ready in cycle 2, rvalid_o = 1 and err_o = 0 in cycle 3.
REQ-040 Read 0x100 after REQ-039 -> rdata_o = 0xDEADBEEF with rvalid_o in cycle 3, and rdata_o held after.
REQ-041 Write where aw_ready is delayed 3 cycles and w_ready is immediate -> w_valid drops after cycle 1, aw_valid stays high with stable payload, exactly one rvalid_o.
REQ-042 Read answered with DECERR -> rvalid_o = 1 and err_o = 1 for one cycle; the next OKAY read gives err_o = 0.
REQ-043 req_i held high for 4 accesses -> gnt_o only in IDLE, grants 3 cycles apart, no overlap on AXI.
REQ-044 rst asserted in WR_RESP -> all outputs 0 the next cycle, no rvalid_o, FSM in IDLE, and the next request completes normally.

Source files
------------

// File: rtl/data_mem_axi_pkg.sv
// Shared types and AXI constants for the data-memory AXI master.
// Holds the FSM state encoding, response/burst codes and small decode helpers.
package data_mem_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam logic [1:0] INCR   = 2'b01;

    // Bytes-per-beat encoding for the supported 32/64-bit data widths.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        if (data_width == 32'd64) begin
            axi_size = 3'd3;
        end else begin
            axi_size = 3'd2;
        end
    endfunction

    function automatic logic resp_is_error(input logic [1:0] resp);
        case (resp)
            OKAY:    resp_is_error = 1'b0;
            EXOKAY:  resp_is_error = 1'b0;
            SLVERR:  resp_is_error = 1'b1;
            DECERR:  resp_is_error = 1'b1;
            default: resp_is_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle shared between the data-memory master and the slave memory.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/data_mem_axi_master.sv
// Single-outstanding bridge from the core data-memory request port to AXI4.
// Each granted request becomes one single-beat AXI read or write; completion is a one-cycle rvalid_o pulse.
module data_mem_axi_master
    import data_mem_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH      = 32,
    parameter int unsigned AXI_DATA_WIDTH      = 32,
    parameter int unsigned AXI_ID_MASTER_WIDTH = 4,
    parameter int unsigned AXI_USER_WIDTH      = 1,
    parameter logic [AXI_ID_MASTER_WIDTH-1:0] AXI_ID = {AXI_ID_MASTER_WIDTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic                        we_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    AXI_BUS.Master                      master
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  AXI_SIZE   = axi_size(AXI_DATA_WIDTH);

    state_e state_r;
    state_e state_next_s;

    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [STRB_WIDTH-1:0]     be_r;
    logic [AXI_DATA_WIDTH-1:0] wdata_r;
    logic [AXI_DATA_WIDTH-1:0] rdata_r;
    logic                      aw_valid_r;
    logic                      w_valid_r;
    logic                      ar_valid_r;
    logic                      rvalid_r;
    logic                      err_r;

    logic gnt_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic ar_hs_s;
    logic b_hs_s;
    logic r_hs_s;
    logic b_ready_s;
    logic r_ready_s;
    logic aw_done_s;
    logic w_done_s;
    logic unused_s;

    assign b_ready_s = (state_r == WR_RESP);
    assign r_ready_s = (state_r == RD_RESP);
    assign aw_hs_s   = aw_valid_r & master.aw_ready;
    assign w_hs_s    = w_valid_r & master.w_ready;
    assign ar_hs_s   = ar_valid_r & master.ar_ready;
    assign b_hs_s    = b_ready_s & master.b_valid;
    assign r_hs_s    = r_ready_s & master.r_valid;

    // A write channel is finished once its valid is gone or is being accepted now.
    assign aw_done_s = ~aw_valid_r | master.aw_ready;
    assign w_done_s  = ~w_valid_r | master.w_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and grant
    always_comb begin
        state_next_s = state_r;
        gnt_s        = 1'b0;
        case (state_r)
            IDLE: begin
                gnt_s = req_i;
                if (req_i) begin
                    if (we_i) begin
                        state_next_s = WR_REQ;
                    end else begin
                        state_next_s = RD_REQ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR_REQ: begin
                if (aw_done_s && w_done_s) begin
                    state_next_s = WR_RESP;
                end else begin
                    state_next_s = WR_REQ;
                end
            end
            WR_RESP: begin
                if (master.b_valid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WR_RESP;
                end
            end
            RD_REQ: begin
                if (master.ar_ready) begin
                    state_next_s = RD_RESP;
                end else begin
                    state_next_s = RD_REQ;
                end
            end
            RD_RESP: begin
                if (master.r_valid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RD_RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request capture, per-channel valid tracking and completion reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= {AXI_ADDR_WIDTH{1'b0}};
            be_r       <= {STRB_WIDTH{1'b0}};
            wdata_r    <= {AXI_DATA_WIDTH{1'b0}};
            rdata_r    <= {AXI_DATA_WIDTH{1'b0}};
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            ar_valid_r <= 1'b0;
            rvalid_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (gnt_s) begin
                addr_r     <= addr_i;
                be_r       <= be_i;
                wdata_r    <= wdata_i;
                aw_valid_r <= we_i;
                w_valid_r  <= we_i;
                ar_valid_r <= ~we_i;
            end else begin
                if (aw_hs_s) begin
                    aw_valid_r <= 1'b0;
                end
                if (w_hs_s) begin
                    w_valid_r <= 1'b0;
                end
                if (ar_hs_s) begin
                    ar_valid_r <= 1'b0;
                end
            end
            rvalid_r <= b_hs_s | r_hs_s;
            if (b_hs_s) begin
                err_r <= resp_is_error(master.b_resp);
            end else if (r_hs_s) begin
                err_r <= resp_is_error(master.r_resp);
            end else begin
                err_r <= 1'b0;
            end
            if (r_hs_s) begin
                rdata_r <= master.r_data;
            end
        end
    end

    assign gnt_o    = gnt_s;
    assign rvalid_o = rvalid_r;
    assign err_o    = err_r;
    assign rdata_o  = rdata_r;

    assign master.aw_id     = AXI_ID;
    assign master.aw_addr   = addr_r;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = AXI_SIZE;
    assign master.aw_burst  = INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign master.aw_valid  = aw_valid_r;

    assign master.w_data    = wdata_r;
    assign master.w_strb    = be_r;
    assign master.w_last    = 1'b1;
    assign master.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign master.w_valid   = w_valid_r;

    assign master.b_ready   = b_ready_s;

    assign master.ar_id     = AXI_ID;
    assign master.ar_addr   = addr_r;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = AXI_SIZE;
    assign master.ar_burst  = INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign master.ar_valid  = ar_valid_r;

    assign master.r_ready   = r_ready_s;

    // Single-beat, single-ID traffic: IDs, last and user on responses carry no information.
    assign unused_s = ^{master.b_id, master.b_user, master.r_id, master.r_last, master.r_user};

endmodule

// File: tb/tb_data_mem_axi_master.sv
// Directed bench for data_mem_axi_master against a small AXI slave memory model.
module tb_data_mem_axi_master;
    import data_mem_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) axi ();

    data_mem_axi_master #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_MASTER_WIDTH(4),
        .AXI_USER_WIDTH(1), .AXI_ID(4'd0)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .master(axi)
    );

    always #5 clk = ~clk;

    // ---------------- slave memory model ----------------
    logic [31:0] mem [0:255] = '{default: 32'h0};
    int          aw_delay = 0;
    int          aw_wait = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] wr_addr_q = 32'h0, wr_data_q = 32'h0, r_data_q = 32'h0;
    logic [3:0]  wr_strb_q = 4'h0;
    logic [1:0]  b_resp_cfg = OKAY, r_resp_cfg = OKAY;
    logic        spurious_r = 1'b0;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [31:0] wa, wd;
    logic [3:0]  ws;

    assign axi.aw_ready = axi.aw_valid && (aw_wait >= aw_delay);
    assign axi.w_ready  = 1'b1;
    assign axi.ar_ready = 1'b1;
    assign axi.b_valid  = b_pend;
    assign axi.b_resp   = b_resp_cfg;
    assign axi.b_id     = 4'd0;
    assign axi.b_user   = 1'b0;
    assign axi.r_valid  = r_pend | spurious_r;
    assign axi.r_data   = r_data_q;
    assign axi.r_resp   = r_resp_cfg;
    assign axi.r_last   = 1'b1;
    assign axi.r_id     = 4'd0;
    assign axi.r_user   = 1'b0;

    assign aw_hs = axi.aw_valid & axi.aw_ready;
    assign w_hs  = axi.w_valid & axi.w_ready;
    assign ar_hs = axi.ar_valid & axi.ar_ready;
    assign b_hs  = axi.b_valid & axi.b_ready;
    assign r_hs  = axi.r_valid & axi.r_ready;
    assign wa    = aw_hs ? axi.aw_addr : wr_addr_q;
    assign wd    = w_hs ? axi.w_data : wr_data_q;
    assign ws    = w_hs ? axi.w_strb : wr_strb_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (s[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (axi.aw_valid && !axi.aw_ready) aw_wait <= aw_wait + 1;
            else aw_wait <= 0;
            if ((aw_got | aw_hs) && (w_got | w_hs)) begin
                mem[wa[9:2]] <= merge(mem[wa[9:2]], wd, ws);
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; wr_addr_q <= axi.aw_addr; end
                if (w_hs) begin w_got <= 1'b1; wr_data_q <= axi.w_data; wr_strb_q <= axi.w_strb; end
            end
            if (b_hs) b_pend <= 1'b0;
            if (ar_hs) begin r_pend <= 1'b1; r_data_q <= mem[axi.ar_addr[9:2]]; end
            else if (r_hs) r_pend <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; be_i = 4'h0;
        repeat (3) tick();
        rst = 1'b0; #1;
        check("rst_gnt", gnt_o, 1'b0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid}, 3'b000);
        check("rst_readys", {axi.b_ready, axi.r_ready}, 2'b00);

        // Zero-wait write
        tick(); drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF); #1;
        check("wr_gnt", gnt_o, 1'b1);
        tick(); req_i = 1'b0; #1;
        check("wr_c1_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid}, 3'b110);
        check("wr_c1_addr", axi.aw_addr, 32'h100);
        check("wr_c1_data", axi.w_data, 32'hDEADBEEF);
        check("wr_c1_strb", axi.w_strb, 4'hF);
        check("wr_c1_fields", {axi.aw_len, axi.aw_size, axi.aw_burst, axi.w_last, axi.aw_id},
              {8'd0, 3'd2, 2'b01, 1'b1, 4'd0});
        check("wr_c1_zero", {axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_user},
              16'h0);
        tick(); #1;
        check("wr_c2_bready", axi.b_ready, 1'b1);
        check("wr_c2_valids", {axi.aw_valid, axi.w_valid}, 2'b00);
        check("wr_c2_rvalid", rvalid_o, 1'b0);
        tick(); #1;
        check("wr_c3_rvalid", rvalid_o, 1'b1);
        check("wr_c3_err", err_o, 1'b0);
        tick(); #1;
        check("wr_c4_rvalid", rvalid_o, 1'b0);

        // Zero-wait read of the same word
        tick(); drive(1'b0, 32'h100, 32'h0, 4'h0); #1;
        check("rd_gnt", gnt_o, 1'b1);
        tick(); req_i = 1'b0; #1;
        check("rd_c1_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid}, 3'b001);
        check("rd_c1_addr", axi.ar_addr, 32'h100);
        check("rd_c1_fields", {axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id}, {8'd0, 3'd2, 2'b01, 4'd0});
        tick(); #1;
        check("rd_c2_rready", {axi.r_ready, axi.ar_valid}, 2'b10);
        tick(); #1;
        check("rd_c3_rvalid", rvalid_o, 1'b1);
        check("rd_c3_rdata", rdata_o, 32'hDEADBEEF);
        check("rd_c3_err", err_o, 1'b0);
        tick(); #1;
        check("rd_c4_rvalid", rvalid_o, 1'b0);
        check("rd_c4_hold", rdata_o, 32'hDEADBEEF);

        // Write with aw_ready delayed three cycles, half-word strobe
        aw_delay = 3;
        tick(); drive(1'b1, 32'h104, 32'h12345678, 4'h3); #1;
        check("dly_gnt", gnt_o, 1'b1);
        tick(); req_i = 1'b0; #1;
        check("dly_c1_valids", {axi.aw_valid, axi.w_valid}, 2'b11);
        check("dly_c1_strb", axi.w_strb, 4'h3);
        tick(); #1;
        check("dly_c2_valids", {axi.aw_valid, axi.w_valid}, 2'b10);
        check("dly_c2_addr", axi.aw_addr, 32'h104);
        tick(); #1;
        check("dly_c3_aw", {axi.aw_valid, axi.aw_ready, axi.b_ready}, 3'b100);
        check("dly_c3_addr", axi.aw_addr, 32'h104);
        tick(); #1;
        check("dly_c4_aw", {axi.aw_valid, axi.aw_ready}, 2'b11);
        tick(); #1;
        check("dly_c5", {axi.aw_valid, axi.b_ready, rvalid_o}, 3'b010);
        tick(); #1;
        check("dly_c6_rvalid", rvalid_o, 1'b1);
        tick(); #1;
        check("dly_c7_rvalid", rvalid_o, 1'b0);
        aw_delay = 0;

        // DECERR read still returns its data; next OKAY read clears err
        r_resp_cfg = DECERR;
        tick(); drive(1'b0, 32'h104, 32'h0, 4'h0); #1;
        tick(); req_i = 1'b0;
        tick();
        tick(); #1;
        check("dec_rvalid", rvalid_o, 1'b1);
        check("dec_err", err_o, 1'b1);
        check("dec_rdata", rdata_o, 32'h00005678);
        r_resp_cfg = OKAY;
        tick(); #1;
        check("dec_after", {rvalid_o, err_o}, 2'b00);
        tick(); drive(1'b0, 32'h100, 32'h0, 4'h0); #1;
        tick(); req_i = 1'b0;
        tick();
        tick(); #1;
        check("ok_rvalid_err", {rvalid_o, err_o}, 2'b10);
        check("ok_rdata", rdata_o, 32'hDEADBEEF);

        // SLVERR on a write
        b_resp_cfg = SLVERR;
        tick(); drive(1'b1, 32'h10C, 32'h0BADF00D, 4'hF); #1;
        tick(); req_i = 1'b0;
        tick();
        tick(); #1;
        check("slv_rvalid_err", {rvalid_o, err_o}, 2'b11);
        check("slv_rdata_kept", rdata_o, 32'hDEADBEEF);
        b_resp_cfg = OKAY;

        // Stray r_valid while idle must not be consumed
        tick(); spurious_r = 1'b1; #1;
        check("stray_rready", axi.r_ready, 1'b0);
        tick(); spurious_r = 1'b0; #1;
        check("stray_rvalid", rvalid_o, 1'b0);
        check("stray_rdata", rdata_o, 32'hDEADBEEF);

        // req_i held high: four reads, grants 3 cycles apart
        for (int c = 0; c <= 12; c++) begin
            tick();
            req_i = (c <= 9); we_i = 1'b0; addr_i = 32'h100;
            #1;
            check($sformatf("b2b_gnt_c%0d", c), gnt_o, (c % 3 == 0) && (c <= 9));
            check($sformatf("b2b_rvalid_c%0d", c), rvalid_o, (c % 3 == 0) && (c >= 3));
            check($sformatf("b2b_axi_c%0d", c), {axi.ar_valid, axi.r_ready, axi.aw_valid},
                  {(c % 3 == 1) && (c <= 10), (c % 3 == 2) && (c <= 11), 1'b0});
        end

        // Reset while waiting for the write response
        tick(); drive(1'b1, 32'h108, 32'hCAFEF00D, 4'hF); #1;
        check("rr_gnt", gnt_o, 1'b1);
        tick(); req_i = 1'b0; #1;
        check("rr_c1_aw", axi.aw_valid, 1'b1);
        tick(); #1;
        check("rr_c2_bready", axi.b_ready, 1'b1);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check("rr_c3_core", {gnt_o, rvalid_o, err_o}, 3'b000);
        check("rr_c3_rdata", rdata_o, 32'h0);
        check("rr_c3_axi", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 5'b0);
        tick(); #1;
        check("rr_c4_rvalid", rvalid_o, 1'b0);
        tick(); drive(1'b0, 32'h100, 32'h0, 4'h0); #1;
        check("rr_next_gnt", gnt_o, 1'b1);
        tick(); req_i = 1'b0;
        tick();
        tick(); #1;
        check("rr_next_rvalid", rvalid_o, 1'b1);
        check("rr_next_rdata", rdata_o, 32'hDEADBEEF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
